// File: rtl/datapath_pkg.sv
// Shared definitions for the five-stage datapath: opcodes, instruction
// field positions and the decoded stage-register payload.
package datapath_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned IMM_W     = 12;

  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned IE_BIT  = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned R1_LSB  = 17;
  localparam int unsigned R2_LSB  = 12;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT = 4'd5;
  localparam logic [OP_W-1:0] OP_JMP = 4'd7;

  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      op;
    logic                 ie;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] r1;
    logic [REG_IDX_W-1:0] r2;
    logic [IMM_W-1:0]     imm;
  } stage_t;

  function automatic stage_t decode(input logic valid, input logic [INSTR_W-1:0] instr);
    stage_t s;
    s.valid = valid;
    s.op    = instr[OP_LSB +: OP_W];
    s.ie    = instr[IE_BIT];
    s.rd    = instr[RD_LSB +: REG_IDX_W];
    s.r1    = instr[R1_LSB +: REG_IDX_W];
    s.r2    = instr[R2_LSB +: REG_IDX_W];
    s.imm   = instr[IMM_LSB +: IMM_W];
    return s;
  endfunction

  // Register 0 and indices beyond the implemented file are never real storage.
  function automatic logic reg_in_range(input logic [REG_IDX_W-1:0] r, input int unsigned n);
    return (r != '0) && (32'(r) < n);
  endfunction

endpackage

// File: rtl/regfile.sv
// NUM_REGS x XLEN register file: two asynchronous read ports, one
// synchronous write port; r0 and out-of-range indices read 0 and drop writes.
module regfile
  import datapath_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] raddr_a_i,
  input  logic [REG_IDX_W-1:0] raddr_b_i,
  output logic [XLEN-1:0]      rdata_a_c_o,
  output logic [XLEN-1:0]      rdata_b_c_o,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]      wdata_i
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (we_i && reg_in_range(waddr_i, NUM_REGS)) begin
      regs_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_c_o = reg_in_range(raddr_a_i, NUM_REGS) ? regs_q[raddr_a_i[IDX_W-1:0]] : '0;
    rdata_b_c_o = reg_in_range(raddr_b_i, NUM_REGS) ? regs_q[raddr_b_i[IDX_W-1:0]] : '0;
  end

endmodule

// File: rtl/pipe_datapath.sv
// Five-stage (F, D, RF, EX, WB) integer datapath with full operand
// forwarding and a JMP resolved in EX that squashes the two younger stages.
module pipe_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE = 32,
  parameter int unsigned             XLEN         = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = ADDRESS_SIZE'(32'h1000),
  parameter int unsigned             NUM_REGS     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  input  logic                    imem_valid,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    wb_valid,
  output logic [REG_IDX_W-1:0]    wb_rd,
  output logic [XLEN-1:0]         wb_data
);

  logic                    req_q;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic                    d_valid_q, d_valid_d;
  logic [INSTR_W-1:0]      d_instr_q, d_instr_d;
  logic [ADDRESS_SIZE-1:0] d_pc_q, d_pc_d;
  stage_t                  rf_q, rf_d;
  logic [ADDRESS_SIZE-1:0] rf_pc_q, rf_pc_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]         ex_op_q, ex_op_d;
  logic [REG_IDX_W-1:0]    ex_rd_q, ex_rd_d;
  logic [IMM_W-1:0]        ex_imm_q, ex_imm_d;
  logic [ADDRESS_SIZE-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]         ex_a_q, ex_a_d;
  logic [XLEN-1:0]         ex_b_q, ex_b_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0]    wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;

  logic [XLEN-1:0]         rf_rdata_a, rf_rdata_b;
  logic [XLEN-1:0]         alu_res;
  logic                    ex_writes;
  logic                    redirect;
  logic                    fetch_ok;
  logic [ADDRESS_SIZE-1:0] jmp_target;

  regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (reset),
    .raddr_a_i   (rf_q.r1),
    .raddr_b_i   (rf_q.r2),
    .rdata_a_c_o (rf_rdata_a),
    .rdata_b_c_o (rf_rdata_b),
    .we_i        (wb_valid_q),
    .waddr_i     (wb_rd_q),
    .wdata_i     (wb_data_q)
  );

  always_comb begin
    alu_res = '0;
    unique case (ex_op_q)
      OP_ADD:  alu_res = ex_a_q + ex_b_q;
      OP_SUB:  alu_res = ex_a_q - ex_b_q;
      OP_AND:  alu_res = ex_a_q & ex_b_q;
      OP_OR:   alu_res = ex_a_q | ex_b_q;
      OP_XOR:  alu_res = ex_a_q ^ ex_b_q;
      OP_SLT:  alu_res = XLEN'($signed(ex_a_q) < $signed(ex_b_q));
      default: alu_res = '0;
    endcase
  end

  assign ex_writes  = ex_valid_q && (ex_op_q <= OP_SLT);
  assign redirect   = ex_valid_q && (ex_op_q == OP_JMP);
  assign jmp_target = ex_pc_q + ADDRESS_SIZE'($signed({ex_imm_q, 2'b00}));

  // Operand bypass: the instruction one ahead (EX) beats the one two ahead (WB).
  function automatic logic [XLEN-1:0] fwd(input logic [REG_IDX_W-1:0] r,
                                          input logic [XLEN-1:0]      rf_val);
    if (!reg_in_range(r, NUM_REGS)) return '0;
    if (ex_writes && (ex_rd_q == r)) return alu_res;
    if (wb_valid_q && (wb_rd_q == r)) return wb_data_q;
    return rf_val;
  endfunction

  always_comb begin
    fetch_ok   = req_q && imem_valid;
    pc_d       = pc_q;
    d_instr_d  = d_instr_q;
    d_pc_d     = d_pc_q;

    if (redirect)      pc_d = jmp_target;
    else if (fetch_ok) pc_d = pc_q + ADDRESS_SIZE'(4);

    d_valid_d = fetch_ok && !redirect;
    if (fetch_ok) begin
      d_instr_d = imem_rdata;
      d_pc_d    = pc_q;
    end

    rf_d    = decode(d_valid_q && !redirect, d_instr_q);
    rf_pc_d = d_pc_q;

    ex_valid_d = rf_q.valid && !redirect;
    ex_op_d    = rf_q.op;
    ex_rd_d    = rf_q.rd;
    ex_imm_d   = rf_q.imm;
    ex_pc_d    = rf_pc_q;
    ex_a_d     = fwd(rf_q.r1, rf_rdata_a);
    ex_b_d     = rf_q.ie ? XLEN'($signed(rf_q.imm)) : fwd(rf_q.r2, rf_rdata_b);

    wb_valid_d = ex_writes;
    wb_rd_d    = ex_writes ? ex_rd_q : '0;
    wb_data_d  = ex_writes ? alu_res : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q      <= 1'b0;
      pc_q       <= BOOT_ADDRESS;
      d_valid_q  <= 1'b0;
      d_instr_q  <= '0;
      d_pc_q     <= '0;
      rf_q       <= '0;
      rf_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      req_q      <= 1'b1;
      pc_q       <= pc_d;
      d_valid_q  <= d_valid_d;
      d_instr_q  <= d_instr_d;
      d_pc_q     <= d_pc_d;
      rf_q       <= rf_d;
      rf_pc_q    <= rf_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: hand-assembled programs in a small
// instruction memory, checked cycle by cycle against hand-computed results.
module tb_pipe_datapath;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [31:0] prog [64];
  logic        stall;
  logic [31:0] off;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'hF000_0000;

  pipe_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    off        = imem_addr - 32'h1000;
    imem_rdata = prog[off[7:2]];
    imem_valid = imem_req && !stall;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d);
    check({tag, ".valid"}, 64'(wb_valid), 64'(v));
    check({tag, ".rd"},    64'(wb_rd),    64'(rd));
    check({tag, ".data"},  64'(wb_data),  64'(d));
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic ie, input logic [4:0] rd,
                                      input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] imm);
    return {op, ie, rd, r1, r2, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    tick(2);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = NOP;

    // Reset state, then sequential fetch and EX->RF forwarding.
    enter_reset();
    check("rst.req",  64'(imem_req),  64'd0);
    check("rst.addr", 64'(imem_addr), 64'h1000);
    expect_wb("rst.wb", 1'b0, 5'd0, 32'd0);
    prog[0] = enc(4'd0, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
    prog[1] = enc(4'd0, 1'b0, 5'd2, 5'd1, 5'd1, 12'd0);
    release_reset();
    tick(1); check("t1.req", 64'(imem_req), 64'd1); check("t1.addr0", 64'(imem_addr), 64'h1000);
    tick(1); check("t1.addr1", 64'(imem_addr), 64'h1004);
    tick(1); check("t1.addr2", 64'(imem_addr), 64'h1008);
    tick(1); expect_wb("t1.e4", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t1.add5", 1'b1, 5'd1, 32'd5);
    tick(1); expect_wb("t1.add10", 1'b1, 5'd2, 32'd10);
    tick(1); expect_wb("t1.idle", 1'b0, 5'd0, 32'd0);

    // Three-cycle fetch stall mid-stream.
    enter_reset();
    prog[0] = enc(4'd0, 1'b1, 5'd1, 5'd0, 5'd0, 12'd1);
    prog[1] = enc(4'd0, 1'b1, 5'd2, 5'd0, 5'd0, 12'd2);
    prog[2] = enc(4'd0, 1'b1, 5'd3, 5'd0, 5'd0, 12'd3);
    prog[3] = enc(4'd0, 1'b1, 5'd4, 5'd0, 5'd0, 12'd4);
    release_reset();
    tick(3);
    stall = 1'b1;
    tick(1); check("t2.hold1", 64'(imem_addr), 64'h1008);
    tick(1); check("t2.hold2", 64'(imem_addr), 64'h1008); expect_wb("t2.r1", 1'b1, 5'd1, 32'd1);
    tick(1); check("t2.hold3", 64'(imem_addr), 64'h1008); expect_wb("t2.r2", 1'b1, 5'd2, 32'd2);
    stall = 1'b0;
    tick(1); check("t2.resume", 64'(imem_addr), 64'h100C); expect_wb("t2.bub1", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t2.bub2", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t2.bub3", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t2.r3", 1'b1, 5'd3, 32'd3);
    tick(1); expect_wb("t2.r4", 1'b1, 5'd4, 32'd4);

    // JMP +4 words from 0x1000 squashes 0x1004/0x1008 and the 0x100C fetch.
    enter_reset();
    prog[0] = enc(4'd7, 1'b0, 5'd0, 5'd0, 5'd0, 12'd4);
    prog[1] = enc(4'd0, 1'b1, 5'd5, 5'd0, 5'd0, 12'h055);
    prog[2] = enc(4'd0, 1'b1, 5'd6, 5'd0, 5'd0, 12'h066);
    prog[3] = enc(4'd0, 1'b1, 5'd7, 5'd0, 5'd0, 12'h077);
    prog[4] = enc(4'd0, 1'b1, 5'd8, 5'd0, 5'd0, 12'd8);
    prog[5] = enc(4'd0, 1'b1, 5'd9, 5'd0, 5'd0, 12'd9);
    release_reset();
    tick(4); check("t3.addr_pre", 64'(imem_addr), 64'h100C);
    tick(1); check("t3.target", 64'(imem_addr), 64'h1010);
    tick(1); check("t3.next", 64'(imem_addr), 64'h1014); expect_wb("t3.kill1004", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t3.kill1008", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t3.kill100c", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t3.r8", 1'b1, 5'd8, 32'd8);
    tick(1); expect_wb("t3.r9", 1'b1, 5'd9, 32'd9);

    // SUB/SLT signedness, WB and regfile forwarding, sign-extended imm, r0 rules.
    enter_reset();
    prog[0] = enc(4'd1, 1'b1, 5'd3, 5'd0, 5'd0, 12'd1);
    prog[1] = enc(4'd5, 1'b0, 5'd4, 5'd3, 5'd0, 12'd0);
    prog[2] = enc(4'd6, 1'b1, 5'd9, 5'd0, 5'd0, 12'd9);
    prog[3] = enc(4'd4, 1'b0, 5'd5, 5'd3, 5'd4, 12'd0);
    prog[4] = enc(4'd2, 1'b1, 5'd6, 5'd5, 5'd0, 12'h0F0);
    prog[5] = enc(4'd0, 1'b1, 5'd7, 5'd0, 5'd0, 12'h800);
    prog[6] = enc(4'd0, 1'b1, 5'd0, 5'd0, 5'd0, 12'd7);
    prog[7] = enc(4'd0, 1'b0, 5'd8, 5'd0, 5'd0, 12'd0);
    release_reset();
    tick(5); expect_wb("t4.sub", 1'b1, 5'd3, 32'hFFFF_FFFF);
    tick(1); expect_wb("t4.slt", 1'b1, 5'd4, 32'd1);
    tick(1); expect_wb("t4.nop", 1'b0, 5'd0, 32'd0);
    tick(1); expect_wb("t4.xor", 1'b1, 5'd5, 32'hFFFF_FFFE);
    tick(1); expect_wb("t4.and", 1'b1, 5'd6, 32'h0000_00F0);
    tick(1); expect_wb("t4.sext", 1'b1, 5'd7, 32'hFFFF_F800);
    tick(2); expect_wb("t4.r0", 1'b1, 5'd8, 32'd0);

    // Mid-run reset with three instructions in flight.
    enter_reset();
    prog[0] = enc(4'd0, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
    prog[1] = enc(4'd0, 1'b1, 5'd2, 5'd0, 5'd0, 12'd6);
    prog[2] = enc(4'd0, 1'b1, 5'd3, 5'd0, 5'd0, 12'd7);
    prog[3] = enc(4'd0, 1'b1, 5'd4, 5'd0, 5'd0, 12'd8);
    prog[4] = enc(4'd0, 1'b1, 5'd5, 5'd0, 5'd0, 12'd9);
    release_reset();
    tick(5); expect_wb("t5.r1", 1'b1, 5'd1, 32'd5);
    tick(1); expect_wb("t5.r2", 1'b1, 5'd2, 32'd6);
    reset = 1'b0;
    #1;
    expect_wb("t5.abort", 1'b0, 5'd0, 32'd0);
    check("t5.req", 64'(imem_req), 64'd0);
    check("t5.addr", 64'(imem_addr), 64'h1000);
    tick(2); expect_wb("t5.held", 1'b0, 5'd0, 32'd0);
    prog[0] = enc(4'd0, 1'b0, 5'd10, 5'd1, 5'd2, 12'd0);
    prog[1] = enc(4'd0, 1'b1, 5'd11, 5'd3, 5'd0, 12'd1);
    prog[2] = NOP; prog[3] = NOP; prog[4] = NOP;
    release_reset();
    tick(1); check("t5.boot", 64'(imem_addr), 64'h1000);
    tick(4); expect_wb("t5.clr12", 1'b1, 5'd10, 32'd0);
    tick(1); expect_wb("t5.clr3", 1'b1, 5'd11, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 32, meaning PC and fetch-address width.
REQ-002 SHALL have parameter XLEN, default 32, meaning register and ALU data width (16..64).
REQ-003 SHALL have parameter BOOT_ADDRESS, default 32'h1000, meaning PC value after reset.
REQ-004 SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, 2..32).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port imem_req, output, 1, meaning fetch request.
REQ-008 SHALL have port imem_addr, output, ADDRESS_SIZE, meaning fetch address (= PC).
REQ-009 SHALL have port imem_valid, input, 1, meaning imem_rdata is valid for imem_addr this cycle.
REQ-010 SHALL have port imem_rdata, input, 32, meaning instruction word.
REQ-011 SHALL have port wb_valid, output, 1, meaning an instruction retires this cycle.
REQ-012 SHALL have port wb_rd, output, 5, meaning the retiring destination register.
REQ-013 SHALL have port wb_data, output, XLEN, meaning the retiring result.

Function
REQ-014 SHALL decode instr[31:28] op, [27] ie, [26:22] rd, [21:17] r1, [16:12] r2, [11:0] imm, with imm sign-extended to XLEN.
REQ-015 SHALL implement ops 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 7 JMP, with ops 6 and 8-15 as NOPs (no write).
REQ-016 SHALL use the imm as operand2 when ie=1, else reg[r2], with arithmetic modulo 2^XLEN.
REQ-017 SHALL have five stages, F, D, RF, EX and WB, each carrying a valid bit.
REQ-018 SHALL present wb_valid for an instruction fetched (imem_valid=1) at edge t in the cycle after edge t+3, writing the register file at the end of that cycle.
REQ-019 SHALL advance PC by 4 and capture the instruction into D with valid=1 when imem_valid=1, and otherwise hold PC and insert a bubble (D valid=0).
REQ-020 SHALL forward RF-stage operands with priority EX result > WB result > register file, so that back-to-back dependents need no stall.
REQ-021 SHALL make register 0 read 0 and never write or forward it, and SHALL ignore writes and read 0 for rd/r1/r2 >= NUM_REGS.
REQ-022 SHALL, for a valid JMP in EX, load PC with EX_pc + (imm<<2) (truncated to ADDRESS_SIZE), clear the D and RF valid bits, discard the current fetch, and write no register.
REQ-023 SHALL let a JMP redirect win over imem_valid=0 in the same cycle.
REQ-024 SHALL drive wb_rd and wb_data to 0 whenever wb_valid=0.

Reset
REQ-025 SHALL, while reset=0, set PC to BOOT_ADDRESS, clear all valid bits, clear all registers to 0, and drive imem_req=0, wb_valid=0, wb_rd=0 and wb_data=0.
REQ-026 SHALL assert imem_req from the first cycle after reset deasserts, and SHALL abort in-flight instructions on mid-run reset with no writeback.

Structure
REQ-027 SHALL place opcode constants, instruction field positions and the stage-register typedef in shared package datapath_pkg.
REQ-028 SHALL use one sub-module, regfile (two asynchronous read ports, one synchronous write port, NUM_REGS x XLEN).

Verification
REQ-029 SHALL verify that after reset release imem_addr=0x1000, then 0x1004 and 0x1008 on consecutive cycles with imem_valid=1.
REQ-030 SHALL verify that ADD r1=r0+imm 5 followed by ADD r2=r1+r1 (ie=0) gives wb_data 5, then 10, on consecutive cycles.
REQ-031 SHALL verify that imem_valid low for 3 cycles mid-stream holds imem_addr, gives 3 bubble cycles (wb_valid=0) and loses no instruction.
REQ-032 SHALL verify that JMP imm=4 at 0x1000 fetches 0x1010 next, and that the two younger instructions (0x1004, 0x1008) never retire.
REQ-033 SHALL verify that SUB r3 = r0 - imm 1 gives all-ones, and that SLT r4 = r3 < r0 gives 1.
REQ-034 SHALL verify that reset asserted with 3 instructions in flight gives wb_valid=0 immediately, registers read 0, and imem_addr=0x1000 after release.
